// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoder scan controller and its arbiter.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  // Channel index {a,b} to decoder output mapping
  localparam ch_idx_t CH_C = 2'd3;
  localparam ch_idx_t CH_D = 2'd2;
  localparam ch_idx_t CH_E = 2'd1;
  localparam ch_idx_t CH_F = 2'd0;

endpackage

// File: rtl/rr_pick4.sv
// Combinational four-way round-robin winner select; the channel after rr_ptr has top priority.
module rr_pick4
  import decoder_pkg::*;
(
  input  logic [3:0] req,
  input  ch_idx_t    rr_ptr,
  output logic       valid,
  output ch_idx_t    idx
);

  // Scan from lowest to highest priority so the highest-priority hit is written last
  always_comb begin
    ch_idx_t cand;
    cand  = rr_ptr;
    valid = 1'b0;
    idx   = 2'd0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand  = rr_ptr + 2'(k);
      valid = valid | req[cand];
      idx   = req[cand] ? cand : idx;
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Round-robin arbiter driving the 2-to-4 decoder select/enable with bounded hold and dead time.
module decoder_scan_ctrl
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic       sel_a,
  output logic       sel_b,
  output logic       en,
  output logic       busy,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nx;
  ch_idx_t          rr_ptr_r, rr_ptr_nx;
  ch_idx_t          sel_r, sel_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic             en_r, en_nx;
  logic             busy_r, busy_nx;
  logic             timeout_r, timeout_nx;
  logic             pick_valid_s;
  ch_idx_t          pick_idx_s;
  logic             release_s;

  rr_pick4 u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .valid  (pick_valid_s),
    .idx    (pick_idx_s)
  );

  // Only the granted channel's done/req can end a grant early
  assign release_s = done[sel_r] | ~req[sel_r];

  // State and output registers; async reset drops en without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rr_ptr_r  <= CH_C;
      sel_r     <= CH_F;
      cnt_r     <= CNT_ZERO;
      en_r      <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nx;
      rr_ptr_r  <= rr_ptr_nx;
      sel_r     <= sel_nx;
      cnt_r     <= cnt_nx;
      en_r      <= en_nx;
      busy_r    <= busy_nx;
      timeout_r <= timeout_nx;
    end
  end

  // Next-state and next-output logic; selects only move on the IDLE->GRANT edge
  always_comb begin
    state_nx   = state_r;
    rr_ptr_nx  = rr_ptr_r;
    sel_nx     = sel_r;
    cnt_nx     = cnt_r;
    en_nx      = en_r;
    busy_nx    = busy_r;
    timeout_nx = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_nx  = GRANT;
          sel_nx    = pick_idx_s;
          rr_ptr_nx = pick_idx_s;
          cnt_nx    = HOLD_LOAD;
          en_nx     = 1'b1;
          busy_nx   = 1'b1;
        end else begin
          en_nx = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_nx = GAP;
          en_nx    = 1'b0;
          cnt_nx   = GAP_LOAD;
        end else if (cnt_r == CNT_ZERO) begin
          state_nx   = GAP;
          en_nx      = 1'b0;
          timeout_nx = 1'b1;
          cnt_nx     = GAP_LOAD;
        end else begin
          cnt_nx = cnt_r - CNT_ONE;
        end
      end
      GAP: begin
        en_nx = 1'b0;
        if (cnt_r == CNT_ZERO) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end else begin
          cnt_nx = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        en_nx    = 1'b0;
        busy_nx  = 1'b0;
        cnt_nx   = CNT_ZERO;
      end
    endcase
  end

  assign sel_a   = sel_r[1];
  assign sel_b   = sel_r[0];
  assign en      = en_r;
  assign busy    = busy_r;
  assign timeout = timeout_r;

endmodule
